// File: rtl/registro_pkg.sv
// rtl/registro_pkg.sv - shared widths and opcodes for the register file
package registro_pkg;

  localparam int REG_DATA_W = 8;
  localparam int REG_ADDR_W = 3;

  typedef logic [1:0] op_t;

  localparam op_t OP_HOLD = 2'b00;
  localparam op_t OP_LOAD = 2'b01;
  localparam op_t OP_COPY = 2'b10;
  localparam op_t OP_CLR  = 2'b11;

endpackage

// File: rtl/registro_read_mux.sv
// rtl/registro_read_mux.sv - combinational N:1 register read mux over a flattened register array
module registro_read_mux
  import registro_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [(2**ADDR_W)*DATA_W-1:0] data,
  input  logic [ADDR_W-1:0]             sel,
  output logic [DATA_W-1:0]             y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      if (sel == ADDR_W'(i)) y = data[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/registro_de_datos.sv
// rtl/registro_de_datos.sv - eight-entry register file, one write port, two combinational read ports
module registro_de_datos
  import registro_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              i_Timming,
  input  logic              i_Rst,
  input  logic [DATA_W-1:0] i_Datos,
  input  logic [1:0]        i_Lectura_escritura,
  input  logic [ADDR_W-1:0] i_Seleccion_registro_escritura,
  input  logic [ADDR_W-1:0] i_Seleccion_registro_lectura,
  input  logic [ADDR_W-1:0] i_Control_RX,
  input  logic [ADDR_W-1:0] i_Control_RY,
  output logic [DATA_W-1:0] o_RX,
  output logic [DATA_W-1:0] o_RY
);

  localparam int N_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]        regs [N_REGS];
  logic [N_REGS*DATA_W-1:0] regs_flat;

  // Copy reads the pre-edge source, so rsel == wsel naturally leaves the register as is.
  always_ff @(posedge i_Timming) begin
    if (i_Rst) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else begin
      case (op_t'(i_Lectura_escritura))
        OP_LOAD: regs[i_Seleccion_registro_escritura] <= i_Datos;
        OP_COPY: regs[i_Seleccion_registro_escritura] <= regs[i_Seleccion_registro_lectura];
        OP_CLR:  regs[i_Seleccion_registro_escritura] <= '0;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

  registro_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_rx (
    .data (regs_flat),
    .sel  (i_Control_RX),
    .y    (o_RX)
  );

  registro_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_ry (
    .data (regs_flat),
    .sel  (i_Control_RY),
    .y    (o_RY)
  );

endmodule

// File: tb/tb_registro_de_datos.sv
// tb/tb_registro_de_datos.sv - directed vector bench for registro_de_datos
module tb_registro_de_datos;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] datos;
  logic [1:0] op;
  logic [2:0] wsel, rsel, crx, cry;
  logic [7:0] rx, ry;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  registro_de_datos dut (
    .i_Timming                      (clk),
    .i_Rst                          (rst),
    .i_Datos                        (datos),
    .i_Lectura_escritura            (op),
    .i_Seleccion_registro_escritura (wsel),
    .i_Seleccion_registro_lectura   (rsel),
    .i_Control_RX                   (crx),
    .i_Control_RY                   (cry),
    .o_RX                           (rx),
    .o_RY                           (ry)
  );

  typedef struct {
    logic       rst;
    logic [1:0] op;
    logic [2:0] wsel;
    logic [2:0] rsel;
    logic [7:0] datos;
    logic [2:0] crx;
    logic [2:0] cry;
    logic [7:0] exp_rx;
    logic [7:0] exp_ry;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic sweep_zero(input string name);
    for (int i = 0; i < 8; i++) begin
      crx = 3'(i);
      cry = 3'(7 - i);
      #1;
      check($sformatf("%s rx[%0d]", name, i), rx, 8'h00);
      check($sformatf("%s ry[%0d]", name, 7 - i), ry, 8'h00);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst   op     w  r  datos  rx ry  exp_rx exp_ry
    vecs[0]  = '{1'b1, 2'b00, 0, 0, 8'h00, 1, 5, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 2'b01, 1, 0, 8'hE7, 1, 5, 8'hE7, 8'h00};
    vecs[2]  = '{1'b0, 2'b01, 5, 0, 8'hFF, 1, 5, 8'hE7, 8'hFF};
    vecs[3]  = '{1'b0, 2'b00, 1, 0, 8'h3C, 1, 5, 8'hE7, 8'hFF};
    vecs[4]  = '{1'b0, 2'b00, 1, 0, 8'h3C, 1, 5, 8'hE7, 8'hFF};
    vecs[5]  = '{1'b0, 2'b10, 7, 1, 8'h00, 7, 1, 8'hE7, 8'hE7};
    vecs[6]  = '{1'b0, 2'b10, 7, 7, 8'h00, 7, 1, 8'hE7, 8'hE7};
    vecs[7]  = '{1'b0, 2'b11, 5, 0, 8'hFF, 5, 7, 8'h00, 8'hE7};
    vecs[8]  = '{1'b0, 2'b00, 0, 0, 8'h00, 1, 5, 8'hE7, 8'h00};
    vecs[9]  = '{1'b0, 2'b01, 0, 0, 8'h5A, 0, 0, 8'h5A, 8'h5A};
    vecs[10] = '{1'b0, 2'b10, 3, 0, 8'h00, 3, 1, 8'h5A, 8'hE7};
    vecs[11] = '{1'b0, 2'b01, 6, 0, 8'h81, 6, 3, 8'h81, 8'h5A};
    vecs[12] = '{1'b1, 2'b01, 2, 0, 8'hAA, 2, 1, 8'h00, 8'h00};

    rst = 1'b1; op = 2'b00; datos = 8'h00; wsel = 0; rsel = 0; crx = 1; cry = 5;
    @(posedge clk); #1;
    check("reset rx", rx, 8'h00);
    check("reset ry", ry, 8'h00);
    sweep_zero("reset sweep");

    // No write-through: old contents visible until the edge.
    @(negedge clk);
    rst = 1'b0; op = 2'b01; wsel = 4; datos = 8'hC3; crx = 4; cry = 4;
    #1;
    check("pre-edge rx", rx, 8'h00);
    check("pre-edge ry", ry, 8'h00);
    @(posedge clk); #1;
    check("post-edge rx", rx, 8'hC3);
    check("post-edge ry", ry, 8'hC3);
    @(negedge clk);
    op = 2'b00;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; op = vecs[i].op; wsel = vecs[i].wsel; rsel = vecs[i].rsel;
      datos = vecs[i].datos; crx = vecs[i].crx; cry = vecs[i].cry;
      @(posedge clk); #1;
      check($sformatf("vec%0d rx", i), rx, vecs[i].exp_rx);
      check($sformatf("vec%0d ry", i), ry, vecs[i].exp_ry);
    end

    @(negedge clk);
    rst = 1'b0; op = 2'b00;
    sweep_zero("post reset-during-write sweep");

    // Combinational read: control change seen without a clock edge.
    @(negedge clk);
    op = 2'b01; wsel = 7; datos = 8'h96;
    @(posedge clk); #1;
    op = 2'b00;
    crx = 7; cry = 0; #1;
    check("comb rx r7", rx, 8'h96);
    check("comb ry r0", ry, 8'h00);
    crx = 0; cry = 7; #1;
    check("comb rx r0", rx, 8'h00);
    check("comb ry r7", ry, 8'h96);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
